id_ex_latch: RTL

ID/EX pipeline register for the five-stage MIPS core. It captures decoded control, register-file read data and the raw instruction word from the decode stage, and presents them to execute and to the forwarding unit. The forwarding unit reads `imemload_id_ex_output[25:21]` and `[20:16]` from this register. The block also detects load-use hazards, stalls the front end for one advance, and inserts a bubble. It accepts branch/jump flushes and latches them while the pipeline is frozen.

---
 rtl/cpu_types_pkg.sv | 57 +++++
 rtl/id_ex_latch_if.sv | 59 +++++
 rtl/id_ex_latch_hazard_detect.sv | 22 ++
 rtl/id_ex_latch.sv | 82 ++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core types plus the ID/EX register layout and its bubble value.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    word_t    imemload;
    word_t    npc;
    word_t    rdat1;
    word_t    rdat2;
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     alusrc;
    logic     branch;
    logic     jump;
    logic [1:0] memtoreg;
    aluop_t   aluop;
    regbits_t branchdest;
    logic     valid;
  } id_ex_t;

  // SLL $0,$0,0 with every control bit cleared and the slot marked empty.
  localparam id_ex_t BUBBLE_ID_EX = '{
    imemload:   NOP_INSTR,
    npc:        '0,
    rdat1:      '0,
    rdat2:      '0,
    regwrite:   1'b0,
    memread:    1'b0,
    memwrite:   1'b0,
    alusrc:     1'b0,
    branch:     1'b0,
    jump:       1'b0,
    memtoreg:   2'd0,
    aluop:      ALU_SLL,
    branchdest: '0,
    valid:      1'b0
  };

endpackage

// File: rtl/id_ex_latch_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX pipeline register.
interface id_ex_latch_if;
  import cpu_types_pkg::*;

  logic       pipe_en;
  logic       flush;
  word_t      imemload_if_id_output;
  word_t      npc_if_id_output;
  word_t      rdat1;
  word_t      rdat2;
  logic       regwrite;
  logic       memread;
  logic       memwrite;
  logic       alusrc;
  logic       branch;
  logic       jump;
  logic [1:0] memtoreg;
  aluop_t     aluop;
  regbits_t   branchdest_input;

  word_t      imemload_id_ex_output;
  word_t      npc_id_ex_output;
  word_t      rdat1_id_ex_output;
  word_t      rdat2_id_ex_output;
  logic       regwrite_id_ex_output;
  logic       memread_id_ex_output;
  logic       memwrite_id_ex_output;
  logic       alusrc_id_ex_output;
  logic       branch_id_ex_output;
  logic       jump_id_ex_output;
  logic [1:0] memtoreg_id_ex_output;
  aluop_t     aluop_id_ex_output;
  regbits_t   branchdest_id_ex_output;
  logic       valid_id_ex_output;
  logic       stall_id;

  modport master (
    output pipe_en, flush, imemload_if_id_output, npc_if_id_output, rdat1, rdat2,
           regwrite, memread, memwrite, alusrc, branch, jump, memtoreg, aluop,
           branchdest_input,
    input  imemload_id_ex_output, npc_id_ex_output, rdat1_id_ex_output,
           rdat2_id_ex_output, regwrite_id_ex_output, memread_id_ex_output,
           memwrite_id_ex_output, alusrc_id_ex_output, branch_id_ex_output,
           jump_id_ex_output, memtoreg_id_ex_output, aluop_id_ex_output,
           branchdest_id_ex_output, valid_id_ex_output, stall_id
  );

  modport slave (
    input  pipe_en, flush, imemload_if_id_output, npc_if_id_output, rdat1, rdat2,
           regwrite, memread, memwrite, alusrc, branch, jump, memtoreg, aluop,
           branchdest_input,
    output imemload_id_ex_output, npc_id_ex_output, rdat1_id_ex_output,
           rdat2_id_ex_output, regwrite_id_ex_output, memread_id_ex_output,
           memwrite_id_ex_output, alusrc_id_ex_output, branch_id_ex_output,
           jump_id_ex_output, memtoreg_id_ex_output, aluop_id_ex_output,
           branchdest_id_ex_output, valid_id_ex_output, stall_id
  );

endinterface

// File: rtl/id_ex_latch_hazard_detect.sv
// Load-use hazard between the load in ID/EX and the instruction in decode.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     valid_i,
  input  logic     memread_i,
  input  regbits_t dest_i,
  input  regbits_t rs_i,
  input  regbits_t rt_i,
  input  logic     flush_eff_i,
  output logic     hazard_o,
  output logic     stall_o
);

  always_comb begin
    hazard_o = valid_i & memread_i & (dest_i != '0) &
               ((dest_i == rs_i) | (dest_i == rt_i));
    // A pending squash kills the decode instruction, so holding it is pointless.
    stall_o  = hazard_o & ~flush_eff_i;
  end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion and deferred flush.
module id_ex_latch
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  id_ex_latch_if.slave     bus
);

  id_ex_t id_ex_q, id_ex_d;
  id_ex_t id_ex_in;
  logic   flush_pend_q, flush_pend_d;
  logic   flush_eff;
  logic   hazard;

  assign flush_eff = bus.flush | flush_pend_q;

  hazard_detect u_hazard_detect (
    .valid_i     (id_ex_q.valid),
    .memread_i   (id_ex_q.memread),
    .dest_i      (id_ex_q.branchdest),
    .rs_i        (bus.imemload_if_id_output[25:21]),
    .rt_i        (bus.imemload_if_id_output[20:16]),
    .flush_eff_i (flush_eff),
    .hazard_o    (hazard),
    .stall_o     (bus.stall_id)
  );

  always_comb begin
    id_ex_in = '{
      imemload:   bus.imemload_if_id_output,
      npc:        bus.npc_if_id_output,
      rdat1:      bus.rdat1,
      rdat2:      bus.rdat2,
      regwrite:   bus.regwrite,
      memread:    bus.memread,
      memwrite:   bus.memwrite,
      alusrc:     bus.alusrc,
      branch:     bus.branch,
      jump:       bus.jump,
      memtoreg:   bus.memtoreg,
      aluop:      bus.aluop,
      branchdest: bus.branchdest_input,
      valid:      1'b1
    };
  end

  always_comb begin
    id_ex_d      = id_ex_q;
    flush_pend_d = flush_pend_q | bus.flush;
    if (bus.pipe_en) begin
      flush_pend_d = 1'b0;
      id_ex_d      = (flush_eff | hazard) ? BUBBLE_ID_EX : id_ex_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      id_ex_q      <= BUBBLE_ID_EX;
      flush_pend_q <= 1'b0;
    end else begin
      id_ex_q      <= id_ex_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.imemload_id_ex_output   = id_ex_q.imemload;
  assign bus.npc_id_ex_output        = id_ex_q.npc;
  assign bus.rdat1_id_ex_output      = id_ex_q.rdat1;
  assign bus.rdat2_id_ex_output      = id_ex_q.rdat2;
  assign bus.regwrite_id_ex_output   = id_ex_q.regwrite;
  assign bus.memread_id_ex_output    = id_ex_q.memread;
  assign bus.memwrite_id_ex_output   = id_ex_q.memwrite;
  assign bus.alusrc_id_ex_output     = id_ex_q.alusrc;
  assign bus.branch_id_ex_output     = id_ex_q.branch;
  assign bus.jump_id_ex_output       = id_ex_q.jump;
  assign bus.memtoreg_id_ex_output   = id_ex_q.memtoreg;
  assign bus.aluop_id_ex_output      = id_ex_q.aluop;
  assign bus.branchdest_id_ex_output = id_ex_q.branchdest;
  assign bus.valid_id_ex_output      = id_ex_q.valid;

endmodule
